// File: rtl/clock_pkg.sv
// Shared constants for the 12-hour hh:mm:ss clock.
// Reset values, field-select encodings and BCD range helpers.
package clock_pkg;

    localparam int CLK_HZ_DEF = 12_000_000;

    localparam logic [7:0] HH_RST = 8'h12;
    localparam logic [7:0] MM_RST = 8'h00;
    localparam logic [7:0] SS_RST = 8'h00;
    localparam logic       PM_RST = 1'b0;

    typedef enum logic [1:0] {
        SEL_HH = 2'b00,
        SEL_MM = 2'b01,
        SEL_SS = 2'b10,
        SEL_PM = 2'b11
    } sel_e;

    // Packed BCD in 00..59
    function automatic logic bcd60_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Packed BCD in 01..12
    function automatic logic hh_ok(input logic [7:0] v);
        return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9))
            || ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    endfunction

endpackage

// File: rtl/bcd_counter_60.sv
// Two-digit packed-BCD counter 00..59 with load and carry-out.
// Used for both the seconds and minutes fields.
module bcd_counter_60
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] ld_val,
    output logic [7:0] q,
    output logic       carry
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Carry fires in the cycle the counter wraps 59 -> 00
    assign carry = inc && !load && (q_q == 8'h59);
    assign q     = q_q;

    // Next value: a valid load wins over increment
    always_comb begin
        q_d = q_q;
        if (load) begin
            if (bcd60_ok(ld_val)) begin
                q_d = ld_val;
            end
        end else if (inc) begin
            if (q_q == 8'h59) begin
                q_d = 8'h00;
            end else if (q_q[3:0] == 4'd9) begin
                q_d = {q_q[7:4] + 4'd1, 4'd0};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] + 4'd1};
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= SS_RST;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/hms_clock_12h.sv
// 12-hour wall clock: 1 Hz prescaler, BCD hh:mm:ss and AM/PM flag.
// Fields are settable through ena/sel/in; a load freezes counting.
module hms_clock_12h
    import clock_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [1:0] sel,
    input  logic [7:0] in,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    hh_q;
    logic [7:0]    hh_d;
    logic          pm_q;
    logic          pm_d;

    logic tick;
    logic ld_hh;
    logic ld_mm;
    logic ld_ss;
    logic ld_pm;
    logic ss_inc;
    logic ss_carry;
    logic mm_carry;

    assign tick   = (cnt_q == CNT_MAX);
    assign ld_hh  = ena && (sel == SEL_HH);
    assign ld_mm  = ena && (sel == SEL_MM);
    assign ld_ss  = ena && (sel == SEL_SS);
    assign ld_pm  = ena && (sel == SEL_PM);
    assign ss_inc = tick && !ena;

    bcd_counter_60 u_ss (
        .clk    (clk),
        .reset  (reset),
        .inc    (ss_inc),
        .load   (ld_ss),
        .ld_val (in),
        .q      (ss),
        .carry  (ss_carry)
    );

    bcd_counter_60 u_mm (
        .clk    (clk),
        .reset  (reset),
        .inc    (ss_carry),
        .load   (ld_mm),
        .ld_val (in),
        .q      (mm),
        .carry  (mm_carry)
    );

    // Prescaler: free-runs, holds while setting, restarts on a seconds load
    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            if (ld_ss && bcd60_ok(in)) begin
                cnt_d = '0;
            end
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Hours 12->01..11->12 and the AM/PM flip on 11->12
    always_comb begin
        hh_d = hh_q;
        pm_d = pm_q;
        if (ena) begin
            if (ld_hh && hh_ok(in)) begin
                hh_d = in;
            end
            if (ld_pm) begin
                pm_d = in[0];
            end
        end else if (mm_carry) begin
            if (hh_q == 8'h12) begin
                hh_d = 8'h01;
            end else if (hh_q == 8'h11) begin
                hh_d = 8'h12;
                pm_d = !pm_q;
            end else if (hh_q[3:0] == 4'd9) begin
                hh_d = 8'h10;
            end else begin
                hh_d = {hh_q[7:4], hh_q[3:0] + 4'd1};
            end
        end
    end

    // Prescaler, hours and pm registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            hh_q  <= HH_RST;
            pm_q  <= PM_RST;
        end else begin
            cnt_q <= cnt_d;
            hh_q  <= hh_d;
            pm_q  <= pm_d;
        end
    end

    assign hh = hh_q;
    assign pm = pm_q;

endmodule

// File: tb/tb_hms_clock_12h.sv
// Bench for hms_clock_12h with a fast prescaler.
// Reference keeps time as seconds since midnight plus a cycle count.
module tb_hms_clock_12h;

    localparam int N = 10;
    localparam logic [1:0] S_HH = 2'b00;
    localparam logic [1:0] S_MM = 2'b01;
    localparam logic [1:0] S_SS = 2'b10;
    localparam logic [1:0] S_PM = 2'b11;

    logic       clk;
    logic       reset;
    logic       ena;
    logic [1:0] sel;
    logic [7:0] din;
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;

    int n_chk;
    int n_fail;
    int t;
    int pc;

    hms_clock_12h #(.CLK_HZ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .sel   (sel),
        .in    (din),
        .pm    (pm),
        .hh    (hh),
        .mm    (mm),
        .ss    (ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit ok60(input logic [7:0] v);
        return (v[7:4] < 6) && (v[3:0] < 10);
    endfunction

    function automatic bit okhh(input logic [7:0] v);
        int n;
        n = from_bcd(v);
        return (v[3:0] < 10) && (v[7:4] < 2) && n >= 1 && n <= 12;
    endfunction

    // {pm, hh, mm, ss} for a time in seconds since 12:00:00 AM
    function automatic logic [24:0] expect_of(input int tt);
        int h24;
        int h12;
        h24 = tt / 3600;
        h12 = h24 % 12;
        if (h12 == 0) h12 = 12;
        return {h24 >= 12, to_bcd(h12), to_bcd((tt / 60) % 60), to_bcd(tt % 60)};
    endfunction

    task automatic model(input bit r, input bit e, input logic [1:0] s,
                         input logic [7:0] v);
        if (r) begin
            t = 0;
            pc = 0;
        end else if (e) begin
            case (s)
                S_HH: if (okhh(v))
                    t = (t / 43200) * 43200 + (from_bcd(v) % 12) * 3600 + t % 3600;
                S_MM: if (ok60(v))
                    t = t - ((t / 60) % 60) * 60 + from_bcd(v) * 60;
                S_SS: if (ok60(v)) begin
                    t = t - t % 60 + from_bcd(v);
                    pc = 0;
                end
                default: t = t % 43200 + (v[0] ? 43200 : 0);
            endcase
        end else if (pc == N - 1) begin
            pc = 0;
            t = (t + 1) % 86400;
        end else begin
            pc = pc + 1;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] s,
                        input logic [7:0] v);
        reset = r;
        ena   = e;
        sel   = s;
        din   = v;
        @(posedge clk);
        model(r, e, s, v);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, S_HH, 8'h00);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, S_HH, 8'h00);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b0, 8'h12, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state got %h want 0120000", {pm, hh, mm, ss});
        end
        idle(9);
        n_chk++;
        if (ss !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_9cyc ss got %h want 00", ss);
        end
        idle(1);
        n_chk++;
        if (ss !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_10cyc ss got %h want 01", ss);
        end
    endtask

    task automatic test_rollover;
        step(1'b0, 1'b1, S_HH, 8'h11);
        step(1'b0, 1'b1, S_MM, 8'h59);
        step(1'b0, 1'b1, S_PM, 8'h00);
        step(1'b0, 1'b1, S_SS, 8'h59);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b0, 8'h11, 8'h59, 8'h59}) begin
            n_fail++;
            $display("FAIL load_115959 got %h want 0115959", {pm, hh, mm, ss});
        end
        idle(N);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b1, 8'h12, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL am_to_pm got %h want 1120000", {pm, hh, mm, ss});
        end
        step(1'b0, 1'b1, S_MM, 8'h59);
        step(1'b0, 1'b1, S_SS, 8'h59);
        idle(N);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b1, 8'h01, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL 12_to_01 got %h want 1010000", {pm, hh, mm, ss});
        end
        step(1'b0, 1'b1, S_HH, 8'h11);
        step(1'b0, 1'b1, S_MM, 8'h59);
        step(1'b0, 1'b1, S_SS, 8'h59);
        idle(N);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b0, 8'h12, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL pm_to_am got %h want 0120000", {pm, hh, mm, ss});
        end
        step(1'b0, 1'b1, S_HH, 8'h09);
        step(1'b0, 1'b1, S_MM, 8'h59);
        step(1'b0, 1'b1, S_SS, 8'h59);
        idle(N);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b0, 8'h10, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL 09_to_10 got %h want 0100000", {pm, hh, mm, ss});
        end
    endtask

    task automatic test_set_range;
        step(1'b0, 1'b1, S_MM, 8'h45);
        n_chk++;
        if (mm !== 8'h45) begin
            n_fail++;
            $display("FAIL set_mm45 got %h want 45", mm);
        end
        step(1'b0, 1'b1, S_MM, 8'h7A);
        step(1'b0, 1'b1, S_MM, 8'h60);
        n_chk++;
        if (mm !== 8'h45) begin
            n_fail++;
            $display("FAIL mm_bad_ignored got %h want 45", mm);
        end
        step(1'b0, 1'b1, S_HH, 8'h07);
        step(1'b0, 1'b1, S_HH, 8'h00);
        step(1'b0, 1'b1, S_HH, 8'h13);
        step(1'b0, 1'b1, S_HH, 8'h0A);
        n_chk++;
        if (hh !== 8'h07) begin
            n_fail++;
            $display("FAIL hh_bad_ignored got %h want 07", hh);
        end
        step(1'b0, 1'b1, S_SS, 8'h33);
        step(1'b0, 1'b1, S_SS, 8'h5A);
        n_chk++;
        if (ss !== 8'h33) begin
            n_fail++;
            $display("FAIL ss_bad_ignored got %h want 33", ss);
        end
        step(1'b0, 1'b1, S_PM, 8'hFF);
        n_chk++;
        if (pm !== 1'b1) begin
            n_fail++;
            $display("FAIL set_pm got %b want 1", pm);
        end
        step(1'b0, 1'b1, S_PM, 8'hFE);
        n_chk++;
        if (pm !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_pm got %b want 0", pm);
        end
    endtask

    task automatic test_freeze;
        logic [24:0] held;
        bit          moved;
        held = expect_of(t);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, S_MM, 8'hFF);
        n_chk++;
        if ({pm, hh, mm, ss} !== held) begin
            n_fail++;
            $display("FAIL freeze got %h want %h", {pm, hh, mm, ss}, held);
        end
        moved = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            idle(1);
            if (ss !== held[7:0]) moved = 1'b1;
        end
        n_chk++;
        if (!moved) begin
            n_fail++;
            $display("FAIL resume ss got %h want change from %h", ss, held[7:0]);
        end
    endtask

    task automatic test_collision;
        logic [7:0] ss0;
        int guard;
        guard = 0;
        while (pc != N - 1 && guard < 2 * N) begin
            idle(1);
            guard++;
        end
        ss0 = ss;
        step(1'b0, 1'b1, S_MM, 8'h30);
        n_chk++;
        if (ss !== ss0 || mm !== 8'h30) begin
            n_fail++;
            $display("FAIL tick_drop got ss=%h mm=%h want ss=%h mm=30", ss, mm, ss0);
        end
        idle(1);
        n_chk++;
        if ({pm, hh, mm, ss} !== expect_of(t)) begin
            n_fail++;
            $display("FAIL after_drop got %h want %h", {pm, hh, mm, ss}, expect_of(t));
        end
    endtask

    task automatic test_mid_reset;
        int guard;
        int k;
        guard = 0;
        while (pc != 5 && guard < 2 * N) begin
            idle(1);
            guard++;
        end
        step(1'b1, 1'b0, S_HH, 8'h00);
        n_chk++;
        if ({pm, hh, mm, ss} !== {1'b0, 8'h12, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset got %h want 0120000", {pm, hh, mm, ss});
        end
        k = 0;
        while (ss !== 8'h01 && k < 3 * N) begin
            idle(1);
            k++;
        end
        n_chk++;
        if (k != N) begin
            n_fail++;
            $display("FAIL mid_reset_latency got %0d cycles want %0d", k, N);
        end
    endtask

    task automatic test_random;
        bit         r;
        bit         e;
        logic [1:0] s;
        logic [7:0] v;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 7) == 0);
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) v = 8'($urandom_range(0, 255));
            else if (s == S_HH) v = to_bcd($urandom_range(1, 12));
            else v = to_bcd($urandom_range(0, 59));
            step(r, e, s, v);
            n_chk++;
            if ({pm, hh, mm, ss} !== expect_of(t)) begin
                n_fail++;
                $display("FAIL random[%0d] got %h want %h", i, {pm, hh, mm, ss},
                         expect_of(t));
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        t      = 0;
        pc     = 0;
        reset  = 1'b1;
        ena    = 1'b0;
        sel    = 2'b00;
        din    = 8'h00;
        @(negedge clk);
        test_reset();
        test_rollover();
        test_set_range();
        test_freeze();
        test_collision();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
